// File: rtl/mcpu_core.sv
// mcpu_core: multi-cycle micro CPU with 16 registers, Z/C/N flags, and a
// FETCH/EXEC/MEM/WB sequencer. Instruction and data buses use req/ready
// handshakes, so wait-stated memories can be attached.
// Optional feature: define MCPU_PERF_EN to build the 32-bit retired-instruction
// counter. Without it, retire_cnt is tied to zero.
module mcpu_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              halted,
    output logic              illegal,
    output logic [31:0]       retire_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC   = 3'd1,
        S_MEM    = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              wr_q, wr_d;
    logic [2:0]        flags_q, flags_d;      // {N, C, Z}
    logic              illegal_q, illegal_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];

    logic [3:0]        op, src1, src2, dest;
    logic [DATA_W-1:0] rs1, rs2;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              br_cond;

    assign op   = ir_q[15:12];
    assign src1 = ir_q[11:8];
    assign src2 = ir_q[7:4];
    assign dest = ir_q[3:0];

    // r0 is never written and resets to zero, so it always reads as zero
    assign rs1 = regs_q[src1];
    assign rs2 = regs_q[src2];

    // BZ (0xC) tests Z and BC (0xD) tests C; opcode bit 0 selects the flag
    assign br_cond = flags_q[{1'b0, op[0]}];

    // ALU for opcodes 1-7; shift amounts of DATA_W or more give zero
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            4'h1: {alu_c, alu_res} = {1'b0, rs1} + {1'b0, rs2};
            4'h2: begin
                alu_res = rs1 - rs2;
                alu_c   = (rs1 < rs2);
            end
            4'h3: alu_res = rs1 & rs2;
            4'h4: alu_res = rs1 | rs2;
            4'h5: alu_res = rs1 ^ rs2;
            4'h6: alu_res = rs1 << rs2;
            4'h7: alu_res = rs1 >> rs2;
            default: ;
        endcase
    end

    // Sequencer: next state, decode/execute, memory capture and writeback
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        next_pc_d    = next_pc_q;
        ir_d         = ir_q;
        result_d     = result_q;
        wr_d         = wr_q;
        flags_d      = flags_q;
        illegal_d    = illegal_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        regs_d       = regs_q;

        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                next_pc_d = pc_q + ADDR_W'(1);
                wr_d      = 1'b0;
                state_d   = S_WB;
                case (op)
                    4'h0: ;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        result_d = alu_res;
                        wr_d     = 1'b1;
                        flags_d  = {alu_res[DATA_W-1], alu_c, (alu_res == '0)};
                    end
                    4'h8: begin
                        result_d = DATA_W'(ir_q[11:4]);
                        wr_d     = 1'b1;
                    end
                    4'h9: begin
                        wr_d        = 1'b1;
                        dmem_we_d   = 1'b0;
                        dmem_addr_d = ADDR_W'(rs1);
                        state_d     = S_MEM;
                    end
                    4'hA: begin
                        dmem_we_d    = 1'b1;
                        dmem_addr_d  = ADDR_W'(rs1);
                        dmem_wdata_d = rs2;
                        state_d      = S_MEM;
                    end
                    4'hB: next_pc_d = ADDR_W'(ir_q[11:0]);
                    4'hC, 4'hD: begin
                        if (br_cond) begin
                            next_pc_d = ADDR_W'(ir_q[11:0]);
                        end
                    end
                    4'hE: state_d = S_HALTED;
                    4'hF: begin
                        state_d   = S_HALTED;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (!dmem_we_q) begin
                        result_d = dmem_rdata;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (wr_q && (dest != 4'd0)) begin
                    regs_d[dest] = result_q;
                end
                pc_d    = next_pc_q;
                state_d = S_FETCH;
            end
            S_HALTED: ;
            default: state_d = S_FETCH;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            next_pc_q    <= '0;
            ir_q         <= '0;
            result_q     <= '0;
            wr_q         <= 1'b0;
            flags_q      <= '0;
            illegal_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            next_pc_q    <= next_pc_d;
            ir_q         <= ir_d;
            result_q     <= result_d;
            wr_q         <= wr_d;
            flags_q      <= flags_d;
            illegal_q    <= illegal_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            regs_q       <= regs_d;
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign halted     = (state_q == S_HALTED);
    assign illegal    = illegal_q;

`ifdef MCPU_PERF_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // One retirement per WB cycle; HALT and illegal never reach WB
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (state_q == S_WB) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // Retirement counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = 32'd0;
`endif

endmodule

// File: doc/mcpu_core.md
# mcpu_core

Parametrised multi-cycle successor to the single-cycle 16-bit micro CPU. Keeps the 4×4-bit instruction format (func|src1|src2|dest) but runs a FETCH/EXEC/MEM/WB state machine with req/ready handshakes on separate instruction and data buses, so slow or wait-stated memories can be attached. Generalised in data width and address width, with flags, conditional branches, halt and illegal-opcode detection. Sits between program memory and data RAM at the top of the microcpu design.

## Interface
- DATA_W, 16, register/ALU/data-bus width; legal range 16–64.
- ADDR_W, 12, instruction and data address width; legal range 8–16.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  ADDR_W  fetch address (= PC).
- imem_rdata  input  16  instruction word.
- imem_ready  input  1  fetch complete; imem_rdata valid this cycle.
- dmem_req  output  1  data access request.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  ADDR_W  data address.
- dmem_wdata  output  DATA_W  store data.
- dmem_rdata  input  DATA_W  load data.
- dmem_ready  input  1  data access complete.
- halted  output  1  core stopped (HALT or illegal).
- illegal  output  1  stopped on opcode 0xF.
- retire_cnt  output  32  retired-instruction count (see Configuration).

## Operation
- 16 registers r0–r15, DATA_W wide; r0 reads 0, writes to r0 discarded. Flags Z, C, N.
- Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 SHL; 7 SHR (logical); 8 LDI rd = zero-extended {src1,src2}; 9 LD rd = mem[rs1]; A ST mem[rs1] = rs2 (dest ignored); B JMP; C BZ (taken if Z); D BC (taken if C); E HALT; F illegal.
- Ops 1–7: rd = rs1 op rs2, mod 2^DATA_W. Z = (result == 0), N = result MSB. ADD: C = carry out. SUB: C = borrow (rs1 < rs2 unsigned). Logic/shift ops clear C. Shift amount = rs2 unsigned; amount ≥ DATA_W yields 0.
- Only ops 1–7 touch flags. LDI, LD, ST, branches leave flags unchanged.
- Branch/jump target = instr[11:0] zero-extended or truncated to ADDR_W. Otherwise PC increments mod 2^ADDR_W (wraps to 0).
- dmem_addr = rs1[ADDR_W-1:0]; dmem_wdata = rs2.
- States: FETCH → EXEC → (MEM if LD/ST) → WB → FETCH. EXEC on E goes to HALTED; on F goes to HALTED with illegal = 1. HALTED is exited only by reset.
- FETCH: imem_req = 1; IR latched at the edge where imem_ready = 1, then EXEC. EXEC: decode, ALU result/branch decision registered. MEM: dmem_req = 1, addr/we/wdata held stable until dmem_ready; LD data captured on that edge. WB: regfile write, PC update, retire_cnt++.
- HALTED: imem_req = dmem_req = 0, halted = 1, PC frozen.

## Timing
- imem_ready/dmem_ready are sampled in the same cycle the request is high; a combinational ready is legal (zero wait).
- Zero-wait latency: non-memory instruction 3 cycles, LD/ST 4 cycles; each wait cycle adds 1.
- Reset values: PC 0, regs 0, flags 0, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, halted 0, illegal 0, retire_cnt 0. State = FETCH, so imem_req = 1 and imem_addr = 0 in the first cycle after reset.
- Reset mid-access: the request drops on the next cycle and the access is abandoned. There is no partial register or PC update.
- Ready asserted while no request is outstanding is ignored.
- In WB, a register write and the next instruction's read never collide, because the next read happens in a later EXEC.

## Configuration
- MCPU_PERF_EN defined: retire_cnt increments by 1 in every WB cycle, wraps at 2^32, clears on reset. HALT/illegal are not counted.
- Not defined: retire_cnt is tied to 0 and no counter logic is built.

## Test plan
- Reset, zero-wait imem with LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 → r3 = 8, Z = 0, C = 0; each instruction takes 3 cycles; retire_cnt = 3 with MCPU_PERF_EN.
- DATA_W = 16: r1 = 0xFFFF (via ADD chain), ADD r3,r1,r1 → r3 = 0xFFFE, C = 1; then SUB r4,r2,r2 → r4 = 0, Z = 1, C = 0; then BZ 0x040 → next imem_addr = 0x040.
- ST r1→mem[r2 = 0x10] with dmem_ready delayed 3 cycles → dmem_req/addr/wdata stable 4 cycles, dmem_we = 1. Then LD r5,[r2] → r5 = stored value, 7-cycle instruction under the same delay.
- PC at 0xFFF (ADDR_W = 12) executing NOP → next imem_addr = 0x000. JMP 0xABC with ADDR_W = 8 → next imem_addr = 0xBC.
- Opcode 0xE → halted = 1 after EXEC, imem_req stays 0 for 20 cycles. Opcode 0xF → halted = 1 and illegal = 1. Write to r0 (ADD r0,r1,r1) → r0 still reads 0.
- Reset asserted during a stalled LD in MEM → dmem_req = 0 the following cycle, PC = 0, r5 unchanged (0), fetch restarts at 0.
